// File: rtl/ram_bus_pkg.sv
// ---------------------------------------------------------------------------
// ram_bus_pkg
//   Shared definitions for masters of the single-port synchronous RAM:
//   default bus widths, FSM state encoding, and the RAM strobe encoding that
//   RAM-side benches also use to decode cs/read/write.
// ---------------------------------------------------------------------------
package ram_bus_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_CAP  = 3'd3,
        ST_RESP = 3'd4
    } state_t;

    // RAM control pin group as seen on the RAM side.
    typedef struct packed {
        logic cs;
        logic read;
        logic write;
    } ram_ctl_t;

    localparam ram_ctl_t CTL_IDLE  = '{cs: 1'b0, read: 1'b0, write: 1'b0};
    localparam ram_ctl_t CTL_READ  = '{cs: 1'b1, read: 1'b1, write: 1'b0};
    localparam ram_ctl_t CTL_WRITE = '{cs: 1'b1, read: 1'b0, write: 1'b1};

    // RAM pin values that must be present while the FSM sits in state s.
    // Used to load the registered strobes one edge ahead of the state.
    function automatic ram_ctl_t ctl_for_state(input state_t s);
        ram_ctl_t ctl;
        case (s)
            ST_WR:          ctl = CTL_WRITE;
            ST_RD, ST_CAP:  ctl = CTL_READ;
            default:        ctl = CTL_IDLE;
        endcase
        return ctl;
    endfunction

    // Only the write state owns the shared data bus.
    function automatic logic bus_oe_for_state(input state_t s);
        return (s == ST_WR);
    endfunction

endpackage

// File: rtl/bus_tristate_drv.sv
// ---------------------------------------------------------------------------
// bus_tristate_drv
//   Bidirectional bus pad for a bus master. Keeps the tristate construct out
//   of the controlling FSM so the same driver can be reused by other masters.
// Ports
//   i_oe    in     1  drive enable; bus released to 'z when low
//   i_dout  in     W  value driven onto the bus while i_oe=1
//   o_din   out    W  current resolved bus value
//   io_bus  inout  W  shared bus
// ---------------------------------------------------------------------------
module bus_tristate_drv #(
    parameter int W = 8
) (
    input  logic         i_oe,
    input  logic [W-1:0] i_dout,
    output logic [W-1:0] o_din,
    inout  wire  [W-1:0] io_bus
);

    assign io_bus = i_oe ? i_dout : {W{1'bz}};
    assign o_din  = io_bus;

endmodule

// File: rtl/ram_bus_master.sv
// ---------------------------------------------------------------------------
// ram_bus_master
//   Sequencer in front of the single-port synchronous RAM. Takes one
//   read/write request at a time over valid/ready, drives the RAM pins and
//   the shared tristate data bus, and returns read data over a valid/ready
//   response channel.
// Ports
//   clk, rst_n                       clock, async active-low reset
//   req_valid/req_ready              request handshake (ready only in IDLE)
//   req_we/req_addr/req_wdata        request contents
//   rsp_valid/rsp_ready/rsp_rdata    read response handshake and data
//   ram_addr/ram_cs/ram_read/ram_write  registered RAM control pins
//   ram_data                         shared data bus, driven only in WR
//
// State | meaning
// IDLE  | ready for a request
// WR    | write strobe on RAM, master drives bus
// RD    | read strobe on RAM, RAM loads its output register
// CAP   | read held, RAM drives bus, sample into rsp_rdata
// RESP  | response valid, waiting for rsp_ready
// ---------------------------------------------------------------------------
module ram_bus_master
    import ram_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_cs,
    output logic              ram_read,
    output logic              ram_write,
    inout  wire  [DATA_W-1:0] ram_data
);

    state_t            r_state;
    ram_ctl_t          r_ctl;
    logic              r_req_ready;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_bus_oe;
    logic [DATA_W-1:0] w_bus_din;

    // Decoded straight from the state register so that an async reset
    // releases the bus in the same instant, without waiting for a clock.
    assign w_bus_oe = bus_oe_for_state(r_state);

    bus_tristate_drv #(
        .W (DATA_W)
    ) u_bus_drv (
        .i_oe   (w_bus_oe),
        .i_dout (r_wdata),
        .o_din  (w_bus_din),
        .io_bus (ram_data)
    );

    // Strobes are loaded on the same edge that enters a state, so the RAM
    // pins are valid for the whole cycle the FSM spends in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ctl       <= CTL_IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_req_ready <= 1'b0;
                        if (req_we) begin
                            r_state <= ST_WR;
                            r_ctl   <= ctl_for_state(ST_WR);
                        end else begin
                            r_state <= ST_RD;
                            r_ctl   <= ctl_for_state(ST_RD);
                        end
                    end else begin
                        // Also covers the first edge after reset release.
                        r_req_ready <= 1'b1;
                    end
                end
                ST_WR: begin
                    r_state     <= ST_IDLE;
                    r_ctl       <= ctl_for_state(ST_IDLE);
                    r_req_ready <= 1'b1;
                end
                ST_RD: begin
                    r_state <= ST_CAP;
                    r_ctl   <= ctl_for_state(ST_CAP);
                end
                ST_CAP: begin
                    r_state     <= ST_RESP;
                    r_ctl       <= ctl_for_state(ST_RESP);
                    r_rsp_rdata <= w_bus_din;
                    r_rsp_valid <= 1'b1;
                end
                ST_RESP: begin
                    if (r_rsp_valid && rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_ctl       <= CTL_IDLE;
                    r_req_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign ram_addr  = r_addr;
    assign ram_cs    = r_ctl.cs;
    assign ram_read  = r_ctl.read;
    assign ram_write = r_ctl.write;

endmodule

// File: tb/tb_ram_bus_master.sv
// ---------------------------------------------------------------------------
// tb_ram_bus_master
//   Directed bench for ram_bus_master together with a behavioural model of
//   the single-port synchronous RAM (memory preloaded with zero).
// ---------------------------------------------------------------------------
module tb_ram_bus_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [7:0] ram_addr;
    logic       ram_cs;
    logic       ram_read;
    logic       ram_write;
    wire  [7:0] ram_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_bus_master #(
        .ADDR_W (8),
        .DATA_W (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_addr  (ram_addr),
        .ram_cs    (ram_cs),
        .ram_read  (ram_read),
        .ram_write (ram_write),
        .ram_data  (ram_data)
    );

    // Synchronous RAM model: writes and output-register loads at posedge,
    // drives the bus from its output register while cs && read.
    logic [7:0] mem [256];
    logic [7:0] ram_q = 8'h00;

    always @(posedge clk) begin
        if (ram_cs && ram_write) mem[ram_addr] <= ram_data;
        if (ram_cs && ram_read)  ram_q <= mem[ram_addr];
    end

    assign ram_data = (ram_cs && ram_read) ? ram_q : 8'bzzzzzzzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("mon_rw_excl", 32'(ram_read && ram_write), 0);
            chk("mon_oe_vs_read", 32'(u_dut.w_bus_oe && ram_read), 0);
            if (ram_cs && ram_read)
                chk("mon_read_bus_known", 32'($isunknown(ram_data)), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 16) begin
            tick();
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(req_ready), 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        wait_ready("wr");
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        tick();                                  // cycle 1: WR
        req_valid = 1'b0;
        req_we    = 1'b0;
        chk("wr_cs",    32'(ram_cs), 1);
        chk("wr_write", 32'(ram_write), 1);
        chk("wr_read",  32'(ram_read), 0);
        chk("wr_addr",  32'(ram_addr), 32'(a));
        chk("wr_bus",   32'(ram_data), 32'(d));
        chk("wr_ready", 32'(req_ready), 0);
        tick();                                  // cycle 2: IDLE
        chk("wr_done_ready", 32'(req_ready), 1);
        chk("wr_done_cs",    32'(ram_cs), 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] exp, input int hold);
        wait_ready("rd");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        tick();                                  // cycle 1: RD
        req_valid = 1'b0;
        chk("rd_cs",        32'(ram_cs), 1);
        chk("rd_read",      32'(ram_read), 1);
        chk("rd_write",     32'(ram_write), 0);
        chk("rd_addr",      32'(ram_addr), 32'(a));
        chk("rd_rsp_valid", 32'(rsp_valid), 0);
        chk("rd_ready",     32'(req_ready), 0);
        tick();                                  // cycle 2: CAP
        chk("cap_read",      32'(ram_read), 1);
        chk("cap_addr",      32'(ram_addr), 32'(a));
        chk("cap_rsp_valid", 32'(rsp_valid), 0);
        tick();                                  // cycle 3: RESP
        chk("resp_valid", 32'(rsp_valid), 1);
        chk("resp_rdata", 32'(rsp_rdata), 32'(exp));
        chk("resp_cs",    32'(ram_cs), 0);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_rdata", 32'(rsp_rdata), 32'(exp));
            chk("hold_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rd_done_valid", 32'(rsp_valid), 0);
        chk("rd_done_ready", 32'(req_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a8;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;

        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 0);
        chk("rst_ram_addr",  32'(ram_addr), 0);
        chk("rst_ram_cs",    32'(ram_cs), 0);
        chk("rst_ram_read",  32'(ram_read), 0);
        chk("rst_ram_write", 32'(ram_write), 0);
        chk("rst_bus_oe",    32'(u_dut.w_bus_oe), 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready_before_clk", 32'(req_ready), 0);
        tick();
        chk("rel_ready_after_clk", 32'(req_ready), 1);

        // rsp_ready with no response pending does nothing.
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("idle_rsp_ready_valid", 32'(rsp_valid), 0);
        chk("idle_rsp_ready_cs",    32'(ram_cs), 0);
        rsp_ready = 1'b0;

        // Write then read back.
        do_write(8'h10, 8'hA5);
        do_read(8'h10, 8'hA5, 0);

        // Response stalled for 5 cycles.
        do_read(8'h10, 8'hA5, 5);

        // Full address sweep with D = ~addr.
        for (int i = 0; i < 256; i++) begin
            a8 = i[7:0];
            do_write(a8, ~a8);
        end
        for (int i = 0; i < 256; i++) begin
            a8 = i[7:0];
            do_read(a8, ~a8, 0);
        end
        do_read(8'hFF, 8'h00, 0);
        do_read(8'h00, 8'hFF, 0);

        // Requests presented outside IDLE are ignored.
        do_write(8'h20, 8'h11);
        do_write(8'h21, 8'h22);
        wait_ready("tg");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h20;
        tick();                                  // RD
        req_we    = 1'b1;
        req_addr  = 8'h21;
        req_wdata = 8'hFF;
        chk("tg_rd_addr", 32'(ram_addr), 'h20);
        tick();                                  // CAP
        chk("tg_cap_addr",  32'(ram_addr), 'h20);
        chk("tg_cap_write", 32'(ram_write), 0);
        tick();                                  // RESP
        chk("tg_resp_valid", 32'(rsp_valid), 1);
        chk("tg_resp_rdata", 32'(rsp_rdata), 'h11);
        chk("tg_resp_write", 32'(ram_write), 0);
        tick();                                  // still RESP
        chk("tg_resp_ready", 32'(req_ready), 0);
        chk("tg_resp_cs",    32'(ram_cs), 0);
        req_valid = 1'b0;
        req_we    = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("tg_done_valid", 32'(rsp_valid), 0);
        do_read(8'h21, 8'h22, 0);
        do_read(8'h20, 8'h11, 0);

        // Reset asserted during CAP.
        do_write(8'h30, 8'h5A);
        wait_ready("rc");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h30;
        tick();                                  // RD
        req_valid = 1'b0;
        tick();                                  // CAP
        chk("rc_in_cap_read", 32'(ram_read), 1);
        rst_n = 1'b0;
        #1;
        chk("rc_cs",        32'(ram_cs), 0);
        chk("rc_read",      32'(ram_read), 0);
        chk("rc_bus_oe",    32'(u_dut.w_bus_oe), 0);
        chk("rc_rsp_valid", 32'(rsp_valid), 0);
        chk("rc_req_ready", 32'(req_ready), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rc_rel_ready", 32'(req_ready), 1);
        chk("rc_rel_valid", 32'(rsp_valid), 0);
        repeat (4) tick();
        chk("rc_no_stale_rsp", 32'(rsp_valid), 0);
        do_read(8'h30, 8'h5A, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
